// File: rtl/data_axi_bridge.sv
// data_axi_bridge: MEM-stage RAM port turned into single-beat AXI transfers.
// Ports: clk, rst, ram_* request/response from MEM, stall_o, bus_error_o,
//   AXI master channels AR/R/AW/W/B (id/len/burst/lock/cache/prot tied off
//   by the SoC wrapper).
// Optional: define DBRIDGE_RESP_CHECK_EN for a sticky bus_error_o on any
//   non-OKAY RRESP/BRESP; otherwise bus_error_o is tied to 0.
module data_axi_bridge (
  input  logic        clk,
  input  logic        rst,
  input  logic        ram_read_enable_i,
  input  logic [31:0] ram_read_addr_i,
  input  logic        ram_write_enable_i,
  input  logic [3:0]  ram_write_select_i,
  input  logic [31:0] ram_write_addr_i,
  input  logic [31:0] ram_write_data_i,
  output logic [31:0] ram_read_data_o,
  output logic        stall_o,
  output logic        bus_error_o,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP,
    DONE
  } state_e;

  state_e      state_q;
  logic        arvalid_q;
  logic        rready_q;
  logic        awvalid_q;
  logic        wvalid_q;
  logic        bready_q;
  logic        aw_done_q;
  logic        w_done_q;
  logic [31:0] araddr_q;
  logic [31:0] awaddr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [31:0] rd_data_q;

  logic aw_hs;
  logic w_hs;
  logic aw_ok;
  logic w_ok;

  assign aw_hs = awvalid_q & awready;
  assign w_hs  = wvalid_q & wready;
  // A channel counts as finished if it completed earlier or completes now.
  assign aw_ok = aw_done_q | aw_hs;
  assign w_ok  = w_done_q | w_hs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      araddr_q  <= '0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rd_data_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (ram_write_enable_i) begin
            awaddr_q  <= ram_write_addr_i;
            wdata_q   <= ram_write_data_i;
            wstrb_q   <= ram_write_select_i;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            state_q   <= WR_REQ;
          end else if (ram_read_enable_i) begin
            araddr_q  <= ram_read_addr_i;
            arvalid_q <= 1'b1;
            state_q   <= RD_ADDR;
          end
        end
        RD_ADDR: begin
          if (arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= RD_DATA;
          end
        end
        RD_DATA: begin
          // len=0, so the first beat is the last; rlast is not needed.
          if (rvalid) begin
            rready_q  <= 1'b0;
            rd_data_q <= rdata;
            state_q   <= DONE;
          end
        end
        WR_REQ: begin
          if (aw_hs) begin
            awvalid_q <= 1'b0;
            aw_done_q <= 1'b1;
          end
          if (w_hs) begin
            wvalid_q <= 1'b0;
            w_done_q <= 1'b1;
          end
          if (aw_ok && w_ok) begin
            bready_q <= 1'b1;
            state_q  <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (bvalid) begin
            bready_q <= 1'b0;
            state_q  <= DONE;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Combinational so the pipeline freezes in the cycle the request shows up.
  assign stall_o = (ram_read_enable_i | ram_write_enable_i) &
                   (state_q != DONE);

  assign ram_read_data_o = rd_data_q;
  assign araddr          = araddr_q;
  assign arsize          = 3'd2;
  assign arvalid         = arvalid_q;
  assign rready          = rready_q;
  assign awaddr          = awaddr_q;
  assign awsize          = 3'd2;
  assign awvalid         = awvalid_q;
  assign wdata           = wdata_q;
  assign wstrb           = wstrb_q;
  assign wlast           = 1'b1;
  assign wvalid          = wvalid_q;
  assign bready          = bready_q;

`ifdef DBRIDGE_RESP_CHECK_EN
  logic bus_err_q;
  logic bus_err_d;
  logic unused_rlast;

  assign unused_rlast = rlast;

  always_comb begin
    bus_err_d = bus_err_q;
    if (rvalid && rready_q && (rresp != 2'b00)) bus_err_d = 1'b1;
    if (bvalid && bready_q && (bresp != 2'b00)) bus_err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) bus_err_q <= 1'b0;
    else     bus_err_q <= bus_err_d;
  end

  assign bus_error_o = bus_err_q;
`else
  logic unused_resp;

  assign unused_resp = ^{rlast, rresp, bresp};
  assign bus_error_o = 1'b0;
`endif

endmodule

// File: tb/tb_data_axi_bridge.sv
// tb_data_axi_bridge: random + directed bench for data_axi_bridge.
// Slave memory with per-channel wait counts; reference memory model.
module tb_data_axi_bridge;

  logic        clk;
  logic        rst;
  logic        ram_read_enable_i;
  logic [31:0] ram_read_addr_i;
  logic        ram_write_enable_i;
  logic [3:0]  ram_write_select_i;
  logic [31:0] ram_write_addr_i;
  logic [31:0] ram_write_data_i;
  logic [31:0] ram_read_data_o;
  logic        stall_o;
  logic        bus_error_o;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  data_axi_bridge dut (
    .clk                (clk),
    .rst                (rst),
    .ram_read_enable_i  (ram_read_enable_i),
    .ram_read_addr_i    (ram_read_addr_i),
    .ram_write_enable_i (ram_write_enable_i),
    .ram_write_select_i (ram_write_select_i),
    .ram_write_addr_i   (ram_write_addr_i),
    .ram_write_data_i   (ram_write_data_i),
    .ram_read_data_o    (ram_read_data_o),
    .stall_o            (stall_o),
    .bus_error_o        (bus_error_o),
    .araddr             (araddr),
    .arsize             (arsize),
    .arvalid            (arvalid),
    .arready            (arready),
    .rdata              (rdata),
    .rresp              (rresp),
    .rlast              (rlast),
    .rvalid             (rvalid),
    .rready             (rready),
    .awaddr             (awaddr),
    .awsize             (awsize),
    .awvalid            (awvalid),
    .awready            (awready),
    .wdata              (wdata),
    .wstrb              (wstrb),
    .wlast              (wlast),
    .wvalid             (wvalid),
    .wready             (wready),
    .bresp              (bresp),
    .bvalid             (bvalid),
    .bready             (bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errs;
  int checks;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // slave knobs and handshake observations
  int ar_wait, r_wait, aw_wait, w_wait, b_wait;
  int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
  int ar_hi, aw_hi, w_hi;
  int cyc;
  int hs_ar_cyc, hs_aw_cyc;
  logic [31:0] hs_araddr, hs_awaddr, hs_wdata;
  logic [3:0]  hs_wstrb;
  logic        hs_wlast;
  logic [1:0]  rresp_v, bresp_v;

  // reference state
  logic [31:0] last_rd;
  logic        exp_err;

  logic [31:0] smem [logic [31:0]];
  logic [31:0] mmem [logic [31:0]];

  function automatic logic [31:0] seed_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] smem_get(input logic [31:0] a);
    return smem.exists(a) ? smem[a] : seed_word(a);
  endfunction

  function automatic logic [31:0] mdl_get(input logic [31:0] a);
    return mmem.exists(a) ? mmem[a] : seed_word(a);
  endfunction

  // AXI slave: ready/valid asserted after a programmable wait
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (arvalid) begin
        ar_hi++;
        if (ar_cnt >= ar_wait) begin
          arready   = 1'b1;
          hs_araddr = araddr;
          hs_ar_cyc = cyc;
        end else begin
          arready = 1'b0;
          ar_cnt++;
        end
      end else begin
        arready = 1'b0;
        ar_cnt  = 0;
      end
      if (rready) begin
        if (r_cnt >= r_wait) begin
          rvalid = 1'b1;
          rlast  = 1'b1;
          rdata  = smem_get(hs_araddr);
          rresp  = rresp_v;
        end else begin
          rvalid = 1'b0;
          rlast  = 1'b0;
          rdata  = $urandom;
          r_cnt++;
        end
      end else begin
        rvalid = 1'b0;
        rlast  = 1'b0;
        rdata  = $urandom;
        r_cnt  = 0;
      end
      if (awvalid) begin
        aw_hi++;
        if (aw_cnt >= aw_wait) begin
          awready   = 1'b1;
          hs_awaddr = awaddr;
          hs_aw_cyc = cyc;
        end else begin
          awready = 1'b0;
          aw_cnt++;
        end
      end else begin
        awready = 1'b0;
        aw_cnt  = 0;
      end
      if (wvalid) begin
        w_hi++;
        if (w_cnt >= w_wait) begin
          wready   = 1'b1;
          hs_wdata = wdata;
          hs_wstrb = wstrb;
          hs_wlast = wlast;
        end else begin
          wready = 1'b0;
          w_cnt++;
        end
      end else begin
        wready = 1'b0;
        w_cnt  = 0;
      end
      if (bready) begin
        if (b_cnt >= b_wait) begin
          bvalid = 1'b1;
          bresp  = bresp_v;
          smem[hs_awaddr] = merge(smem_get(hs_awaddr), hs_wdata, hs_wstrb);
        end else begin
          bvalid = 1'b0;
          b_cnt++;
        end
      end else begin
        bvalid = 1'b0;
        bresp  = 2'b00;
        b_cnt  = 0;
      end
    end
  end

  // Counts stalled cycles until the DONE cycle; old read data must hold.
  task automatic wait_done(output int n);
    n = 0;
    #1;
    while (stall_o && n < 200) begin
      check("rdata_hold", ram_read_data_o, last_rd);
      n++;
      @(negedge clk);
      #1;
    end
    if (stall_o) check("timeout", 32'(stall_o), 0);
  endtask

  task automatic do_read(input logic [31:0] a, input int aw_, input int rw_);
    int n;
    logic [31:0] exp;
    ar_wait = aw_;
    r_wait  = rw_;
    ar_hi   = 0;
    exp     = mdl_get(a);
    ram_read_enable_i = 1'b1;
    ram_read_addr_i   = a;
    wait_done(n);
    check("rd_stall", n, 3 + aw_ + rw_);
    check("rd_data", ram_read_data_o, exp);
    check("araddr", hs_araddr, a);
    check("arvalid_cycles", ar_hi, aw_ + 1);
    check("bus_err", 32'(bus_error_o), 32'(exp_err));
    last_rd = exp;
    ram_read_enable_i = 1'b0;
    ram_read_addr_i   = $urandom;
    @(negedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int aww, input int ww,
                          input int bw);
    int n;
    int mx;
    aw_wait = aww;
    w_wait  = ww;
    b_wait  = bw;
    aw_hi   = 0;
    w_hi    = 0;
    ram_write_enable_i = 1'b1;
    ram_write_addr_i   = a;
    ram_write_data_i   = d;
    ram_write_select_i = s;
    wait_done(n);
    mx = (aww > ww) ? aww : ww;
    check("wr_stall", n, 3 + mx + bw);
    check("awaddr", hs_awaddr, a);
    check("wdata", hs_wdata, d);
    check("wstrb", 32'(hs_wstrb), 32'(s));
    check("wlast", 32'(hs_wlast), 1);
    check("awvalid_cycles", aw_hi, aww + 1);
    check("wvalid_cycles", w_hi, ww + 1);
    check("rd_keep", ram_read_data_o, last_rd);
    check("bus_err", 32'(bus_error_o), 32'(exp_err));
    mmem[a] = merge(mdl_get(a), d, s);
    ram_write_enable_i = 1'b0;
    ram_write_addr_i   = $urandom;
    ram_write_data_i   = $urandom;
    ram_write_select_i = 4'($urandom);
    @(negedge clk);
    #1;
  endtask

  // Both enables together: write first, then the read in the next IDLE.
  task automatic do_dual(input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s);
    int n;
    ar_wait = 0; r_wait = 0; aw_wait = 0; w_wait = 0; b_wait = 0;
    hs_ar_cyc = 0;
    hs_aw_cyc = 0;
    ram_write_enable_i = 1'b1;
    ram_read_enable_i  = 1'b1;
    ram_write_addr_i   = a;
    ram_read_addr_i    = a;
    ram_write_data_i   = d;
    ram_write_select_i = s;
    wait_done(n);
    check("dual_wr_stall", n, 3);
    check("dual_no_ar_yet", hs_ar_cyc, 0);
    mmem[a] = merge(mdl_get(a), d, s);
    ram_write_enable_i = 1'b0;
    @(negedge clk);
    #1;
    wait_done(n);
    check("dual_rd_stall", n, 3);
    check("dual_rd_data", ram_read_data_o, mdl_get(a));
    check("dual_aw_first", 32'(hs_aw_cyc != 0 && hs_aw_cyc < hs_ar_cyc), 1);
    last_rd = mdl_get(a);
    ram_read_enable_i = 1'b0;
    @(negedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    errs = 0; checks = 0; cyc = 0;
    ar_wait = 0; r_wait = 0; aw_wait = 0; w_wait = 0; b_wait = 0;
    ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    ar_hi = 0; aw_hi = 0; w_hi = 0;
    hs_ar_cyc = 0; hs_aw_cyc = 0;
    hs_araddr = '0; hs_awaddr = '0; hs_wdata = '0;
    hs_wstrb = '0; hs_wlast = 1'b0;
    rresp_v = 2'b00; bresp_v = 2'b00;
    arready = 0; awready = 0; wready = 0;
    rvalid = 0; rlast = 0; rdata = '0; rresp = '0;
    bvalid = 0; bresp = '0;
    ram_read_enable_i = 0; ram_write_enable_i = 0;
    ram_read_addr_i = '0; ram_write_addr_i = '0;
    ram_write_data_i = '0; ram_write_select_i = '0;
    last_rd = '0;
    exp_err = 1'b0;
    rst = 1'b1;

    repeat (2) @(negedge clk);
    #1;
    check("rst_valids",
          32'({arvalid, rready, awvalid, wvalid, bready}), 0);
    check("rst_araddr", araddr, 0);
    check("rst_awaddr", awaddr, 0);
    check("rst_wdata", wdata, 0);
    check("rst_wstrb", 32'(wstrb), 0);
    check("rst_rdata", ram_read_data_o, 0);
    check("rst_err", 32'(bus_error_o), 0);
    check("rst_stall", 32'(stall_o), 0);
    check("arsize", 32'(arsize), 2);
    check("awsize", 32'(awsize), 2);
    check("wlast_const", 32'(wlast), 1);
    rst = 1'b0;
    @(negedge clk);
    #1;

    smem[32'h1FC0_0010] = 32'hDEAD_BEEF;
    mmem[32'h1FC0_0010] = 32'hDEAD_BEEF;
    do_read(32'h1FC0_0010, 0, 0);
    do_write(32'h0000_1000, 32'h5A5A_5A5A, 4'b0100, 2, 0, 0);
    do_read(32'h0000_1000, 0, 0);
    do_dual(32'h0000_2000, 32'hCAFE_F00D, 4'b1001);
    do_read(32'h0000_1004, 1, 10);
    do_write(32'h0000_1004, 32'h1357_9BDF, 4'b1111, 0, 3, 2);
    do_read(32'h0000_1004, 2, 1);

    // reset while waiting for read data
    ar_wait = 0;
    r_wait  = 30;
    ram_read_enable_i = 1'b1;
    ram_read_addr_i   = 32'h0000_4000;
    for (int i = 0; i < 20 && !rready; i++) @(negedge clk);
    check("pre_rst_rready", 32'(rready), 1);
    #2 rst = 1'b1;
    #1;
    check("async_rready", 32'(rready), 0);
    check("async_arvalid", 32'(arvalid), 0);
    check("async_rdata", ram_read_data_o, 0);
    ram_read_enable_i = 1'b0;
    #1;
    check("async_stall", 32'(stall_o), 0);
    @(negedge clk);
    rst = 1'b0;
    last_rd = '0;
    #1;
    do_read(32'h0000_4000, 0, 0);

    for (int k = 0; k < 40; k++) begin
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  s;
      int op;
      a  = 32'h0000_3000 + 4 * $urandom_range(0, 7);
      d  = $urandom;
      s  = 4'($urandom);
      op = $urandom_range(0, 4);
      if (op < 2)
        do_read(a, $urandom_range(0, 3), $urandom_range(0, 3));
      else if (op < 4)
        do_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3));
      else
        do_dual(a, d, s);
    end

    // error response on B
    bresp_v = 2'b10;
`ifdef DBRIDGE_RESP_CHECK_EN
    exp_err = 1'b1;
`endif
    do_write(32'h0000_5000, 32'h0F0F_0F0F, 4'b0011, 0, 0, 1);
    bresp_v = 2'b00;
    do_read(32'h0000_5000, 0, 0);
    do_write(32'h0000_5004, 32'h7777_7777, 4'b1000, 1, 1, 0);
    check("err_sticky", 32'(bus_error_o), 32'(exp_err));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
